apb_gpio_arb: RTL and testbench

APB_GPIO_ARB -- requirements
Module: apb_gpio_arb

---
 rtl/apb_gpio_arb.sv | 182 ++++++++++++++++++
 tb/tb_apb_gpio_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_gpio_arb.sv
// apb_gpio_arb: two-requester round-robin arbiter driving one APB4 master port.
// Optional ACCESS wait-state timeout is built when APB_GPIO_ARB_TIMEOUT_EN is defined.
module apb_gpio_arb #(
    parameter int PDATA_SIZE = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    r0_req,
    input  logic [2:0]              r0_addr,
    input  logic                    r0_write,
    input  logic [PDATA_SIZE-1:0]   r0_wdata,
    input  logic [PDATA_SIZE/8-1:0] r0_strb,
    output logic                    r0_ack,
    output logic [PDATA_SIZE-1:0]   r0_rdata,
    output logic                    r0_err,
    input  logic                    r1_req,
    input  logic [2:0]              r1_addr,
    input  logic                    r1_write,
    input  logic [PDATA_SIZE-1:0]   r1_wdata,
    input  logic [PDATA_SIZE/8-1:0] r1_strb,
    output logic                    r1_ack,
    output logic [PDATA_SIZE-1:0]   r1_rdata,
    output logic                    r1_err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [2:0]              PADDR,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int SW = PDATA_SIZE / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  last_q, last_d;
    logic [2:0]            addr_q, addr_d;
    logic                  write_q, write_d;
    logic [PDATA_SIZE-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         strb_q, strb_d;
    logic [PDATA_SIZE-1:0] rd0_q, rd1_q;
    logic                  err0_q, err1_q;

    logic                  cap;
    logic [PDATA_SIZE-1:0] cap_data;
    logic                  cap_err;
    logic                  tmo;

`ifdef APB_GPIO_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tmo = (cnt_q == CW'(TIMEOUT - 1));

    // Counter only runs while ACCESS is stalled; any other state clears it.
    always_comb begin
        cnt_d = '0;
        if (state_q == ACCESS && !PREADY) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        strb_d   = strb_q;
        cap      = 1'b0;
        cap_data = PRDATA;
        cap_err  = PSLVERR;
        unique case (state_q)
            IDLE: begin
                if (r0_req || r1_req) begin
                    // On a tie the requester not served last wins.
                    gnt_d   = (r0_req && r1_req) ? ~last_q : r1_req;
                    last_d  = gnt_d;
                    addr_d  = gnt_d ? r1_addr : r0_addr;
                    write_d = gnt_d ? r1_write : r0_write;
                    wdata_d = gnt_d ? r1_wdata : r0_wdata;
                    strb_d  = gnt_d ? r1_strb : r0_strb;
                    if (!write_d) begin
                        strb_d = '0;
                    end
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY) begin
                    cap     = 1'b1;
                    state_d = DONE;
                end else if (tmo) begin
                    cap      = 1'b1;
                    cap_data = '0;
                    cap_err  = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            if (cap && !gnt_q) begin
                rd0_q  <= cap_data;
                err0_q <= cap_err;
            end
            if (cap && gnt_q) begin
                rd1_q  <= cap_data;
                err1_q <= cap_err;
            end
        end
    end

    assign PSEL     = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE  = (state_q == ACCESS);
    assign PWRITE   = write_q;
    assign PADDR    = addr_q;
    assign PWDATA   = wdata_q;
    assign PSTRB    = strb_q;

    assign r0_ack   = (state_q == DONE) && !gnt_q;
    assign r1_ack   = (state_q == DONE) && gnt_q;
    assign r0_rdata = rd0_q;
    assign r1_rdata = rd1_q;
    assign r0_err   = err0_q;
    assign r1_err   = err1_q;

endmodule

// File: tb/tb_apb_gpio_arb.sv
// tb_apb_gpio_arb: directed and randomized checks of apb_gpio_arb
// against a transaction-level arbitration/response model.
module tb_apb_gpio_arb;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       req[2];
    logic [2:0] addr[2];
    logic       wr[2];
    logic [7:0] wd[2];
    logic [0:0] st[2];
    logic       ack[2];
    logic [7:0] rd[2];
    logic       er[2];
    logic       PSEL, PENABLE, PWRITE;
    logic [2:0] PADDR;
    logic [7:0] PWDATA;
    logic [0:0] PSTRB;
    logic [7:0] PRDATA;
    logic       PREADY, PSLVERR;

    int         checks   = 0;
    int         failures = 0;
    int         last;
    logic [7:0] exp_rd[2];
    logic       exp_er[2];

    always #5 PCLK = ~PCLK;

    apb_gpio_arb #(.PDATA_SIZE(8), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .r0_req(req[0]), .r0_addr(addr[0]), .r0_write(wr[0]),
        .r0_wdata(wd[0]), .r0_strb(st[0]),
        .r0_ack(ack[0]), .r0_rdata(rd[0]), .r0_err(er[0]),
        .r1_req(req[1]), .r1_addr(addr[1]), .r1_write(wr[1]),
        .r1_wdata(wd[1]), .r1_strb(st[1]),
        .r1_ack(ack[1]), .r1_rdata(rd[1]), .r1_err(er[1]),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic step;
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_cmd(input int i);
        addr[i] = 3'($urandom);
        wr[i]   = 1'($urandom);
        wd[i]   = 8'($urandom);
        st[i]   = 1'($urandom);
    endtask

    task automatic model_reset;
        last      = 1;
        exp_rd[0] = 8'h00;
        exp_rd[1] = 8'h00;
        exp_er[0] = 1'b0;
        exp_er[1] = 1'b0;
    endtask

    // Starts at a negedge in IDLE with requests already driven.
    task automatic do_xfer(input int waits, input logic [7:0] prd,
                           input logic serr, input bit keep,
                           input bit raise_other);
        int         w, o;
        logic [2:0] ea;
        logic       ewr;
        logic [7:0] ewd;
        logic [0:0] es;
        chk("idle_psel", 32'(PSEL), 32'(0));
        if (req[0] && req[1]) w = 1 - last;
        else if (req[1]) w = 1;
        else w = 0;
        o    = 1 - w;
        last = w;
        ea   = addr[w];
        ewr  = wr[w];
        ewd  = wd[w];
        es   = wr[w] ? st[w] : 1'b0;
        step;
        chk("setup_psel", 32'(PSEL), 32'(1));
        chk("setup_penable", 32'(PENABLE), 32'(0));
        chk("setup_paddr", 32'(PADDR), 32'(ea));
        chk("setup_pwrite", 32'(PWRITE), 32'(ewr));
        chk("setup_pwdata", 32'(PWDATA), 32'(ewd));
        chk("setup_pstrb", 32'(PSTRB), 32'(es));
        chk("setup_acks", 32'({ack[1], ack[0]}), 32'(0));
        wd[w]   = ~wd[w];
        addr[w] = addr[w] + 3'd1;
        if (raise_other && !req[o]) begin
            req[o] = 1'b1;
            new_cmd(o);
        end
        PREADY = 1'b0;
        for (int k = 0; k <= waits; k++) begin
            step;
            chk("access_sel_en", 32'({PSEL, PENABLE}), 32'(3));
            chk("access_paddr", 32'(PADDR), 32'(ea));
            chk("access_pwdata", 32'(PWDATA), 32'(ewd));
            chk("access_pstrb", 32'(PSTRB), 32'(es));
            chk("access_acks", 32'({ack[1], ack[0]}), 32'(0));
            PRDATA = 8'($urandom);
            if (k == waits) begin
                PREADY  = 1'b1;
                PRDATA  = prd;
                PSLVERR = serr;
            end
        end
        step;
        chk("done_ack_win", 32'(ack[w]), 32'(1));
        chk("done_ack_other", 32'(ack[o]), 32'(0));
        chk("done_rdata", 32'(rd[w]), 32'(prd));
        chk("done_err", 32'(er[w]), 32'(serr));
        chk("hold_rdata", 32'(rd[o]), 32'(exp_rd[o]));
        chk("hold_err", 32'(er[o]), 32'(exp_er[o]));
        chk("done_sel_en", 32'({PSEL, PENABLE}), 32'(0));
        exp_rd[w] = prd;
        exp_er[w] = serr;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = 8'($urandom);
        if (keep) new_cmd(w);
        else req[w] = 1'b0;
        step;
        chk("post_acks", 32'({ack[1], ack[0]}), 32'(0));
        chk("post_psel", 32'(PSEL), 32'(0));
    endtask

    initial begin
        int bad;
        req[0] = 1'b0; req[1] = 1'b0;
        new_cmd(0); new_cmd(1);
        PRDATA = 8'h00; PREADY = 1'b0; PSLVERR = 1'b0;
        PRESET = 1'b1;
        model_reset();
        @(negedge PCLK);
        step;
        chk("rst_ctrl", 32'({PSEL, PENABLE, PWRITE}), 32'(0));
        chk("rst_paddr", 32'(PADDR), 32'(0));
        chk("rst_pwdata", 32'(PWDATA), 32'(0));
        chk("rst_pstrb", 32'(PSTRB), 32'(0));
        chk("rst_acks", 32'({ack[1], ack[0]}), 32'(0));
        chk("rst_rdata", 32'({rd[1], rd[0]}), 32'(0));
        chk("rst_err", 32'({er[1], er[0]}), 32'(0));
        req[0] = 1'b1;
        step;
        chk("rst_ignores_req", 32'(PSEL), 32'(0));
        req[0] = 1'b0;
        PRESET = 1'b0;
        step;

        // r0 write, zero wait states
        req[0] = 1'b1; addr[0] = 3'd1; wr[0] = 1'b1;
        wd[0] = 8'hA5; st[0] = 1'b1;
        do_xfer(0, 8'h5A, 1'b0, 1'b0, 1'b0);

        // r1 read with two wait states
        req[1] = 1'b1; addr[1] = 3'd3; wr[1] = 1'b0;
        wd[1] = 8'h99; st[1] = 1'b1;
        do_xfer(2, 8'h3C, 1'b0, 1'b0, 1'b0);

        // both held: round-robin order
        req[0] = 1'b1; req[1] = 1'b1;
        new_cmd(0); new_cmd(1);
        do_xfer(0, 8'h10, 1'b0, 1'b1, 1'b0);
        do_xfer(1, 8'h21, 1'b0, 1'b1, 1'b0);
        do_xfer(0, 8'h32, 1'b0, 1'b0, 1'b0);
        do_xfer(0, 8'h43, 1'b0, 1'b0, 1'b0);

        // slave error then clean transfer
        req[0] = 1'b1; addr[0] = 3'd2; wr[0] = 1'b0;
        do_xfer(0, 8'h77, 1'b1, 1'b1, 1'b0);
        do_xfer(1, 8'h11, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] && ($urandom % 3) == 0) begin
                    req[i] = 1'b1;
                    new_cmd(i);
                end
            end
            if (!req[0] && !req[1]) begin
                chk("rand_idle_psel", 32'(PSEL), 32'(0));
                step;
            end else begin
                do_xfer(int'($urandom_range(0, 3)), 8'($urandom),
                        1'(($urandom % 4) == 0), 1'($urandom),
                        1'($urandom));
            end
        end
        while (req[0] || req[1]) do_xfer(0, 8'h5C, 1'b0, 1'b0, 1'b0);

        // reset in the middle of ACCESS
        req[0] = 1'b1; new_cmd(0); wr[0] = 1'b0;
        step;
        step;
        chk("pre_rst_access", 32'({PSEL, PENABLE}), 32'(3));
        PRESET = 1'b1;
        req[1] = 1'b1; new_cmd(1);
        addr[0] = 3'd4; addr[1] = 3'd6;
        step;
        chk("midrst_sel_en", 32'({PSEL, PENABLE}), 32'(0));
        chk("midrst_acks", 32'({ack[1], ack[0]}), 32'(0));
        chk("midrst_rdata", 32'({rd[1], rd[0]}), 32'(0));
        chk("midrst_err", 32'({er[1], er[0]}), 32'(0));
        step;
        chk("midrst_hold", 32'(PSEL), 32'(0));
        PRESET = 1'b0;
        model_reset();
        do_xfer(0, 8'h66, 1'b0, 1'b0, 1'b0);
        do_xfer(0, 8'h67, 1'b0, 1'b0, 1'b0);

        // stalled slave
        req[0] = 1'b1; new_cmd(0); wr[0] = 1'b0;
        PRDATA = 8'hFF; PREADY = 1'b0;
        step;
        step;
        bad = 0;
`ifdef APB_GPIO_ARB_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            if (!(PSEL && PENABLE) || ack[0] || ack[1]) bad++;
            step;
        end
        chk("tmo_stall_cycles", 32'(bad), 32'(0));
        chk("tmo_last_access", 32'(PENABLE), 32'(1));
        step;
        chk("tmo_ack", 32'(ack[0]), 32'(1));
        chk("tmo_err", 32'(er[0]), 32'(1));
        chk("tmo_rdata", 32'(rd[0]), 32'(0));
        chk("tmo_sel_en", 32'({PSEL, PENABLE}), 32'(0));
        req[0] = 1'b0;
        step;
`else
        for (int k = 1; k < 100; k++) begin
            if (!(PSEL && PENABLE) || ack[0] || ack[1]) bad++;
            step;
        end
        chk("noto_stall_cycles", 32'(bad), 32'(0));
        chk("noto_in_access", 32'({PSEL, PENABLE}), 32'(3));
        req[0] = 1'b0;
        PRESET = 1'b1;
        step;
        PRESET = 1'b0;
        model_reset();
        step;
`endif
        chk("final_idle", 32'(PSEL), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
